// File: rtl/alu_share_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_share_ctrl_pkg: op codes, flag indices and op legality for the    |
// | shared-ALU controller.                            Revision: 1.0       |
// +-----------------------------------------------------------------------+
package alu_share_ctrl_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b001;
  localparam alu_op_t ALU_AND = 3'b010;
  localparam alu_op_t ALU_OR  = 3'b011;
  localparam alu_op_t ALU_SLT = 3'b101;
  localparam alu_op_t ALU_XOR = 3'b111;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  function automatic logic op_is_legal(input alu_op_t op);
    logic legal;
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_XOR: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu: combinational ALU with {N,Z,C,V} flags.       Revision: 1.0      |
// +-----------------------------------------------------------------------+
module alu
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf;

  always_comb begin
    // SUB is a + ~b + 1, so C is the carry-out (set when no borrow)
    cin    = (op == ALU_SUB);
    b_eff  = cin ? ~b : b;
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
    flags        = '0;
    flags[FLG_N] = result[WIDTH-1];
    flags[FLG_Z] = (result == '0);
    flags[FLG_C] = carry;
    flags[FLG_V] = ovf;
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arb2.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_arb2: two-way round-robin arbiter; prio names the favoured side.   |
// |                                                   Revision: 1.0       |
// +-----------------------------------------------------------------------+
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    // favour the loser next time; hold when idle
    prio_d = prio_q;
    if (gnt != 2'b00) prio_d = gnt[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_share_ctrl: shares one ALU between two requesters with a          |
// | single-entry response buffer.                     Revision: 1.0       |
// +-----------------------------------------------------------------------+
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err
);

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q,    rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_err_q,   rsp_err_d;

  logic             can_issue;
  logic             arb_en;
  logic [1:0]       gnt;
  logic             sel;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [2:0]       alu_op;
  logic [TAG_W-1:0] sel_tag;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  // readiness is forced low while reset is asserted
  assign can_issue = !rsp_valid_q || rsp_ready;
  assign arb_en    = can_issue && !rst;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1_valid, req0_valid}),
    .en  (arb_en),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign sel        = gnt[1];

  always_comb begin
    alu_a   = sel ? req1_a   : req0_a;
    alu_b   = sel ? req1_b   : req0_b;
    alu_op  = sel ? req1_op  : req0_op;
    sel_tag = sel ? req1_tag : req0_tag;
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    if (gnt != 2'b00) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = sel;
      rsp_tag_d   = sel_tag;
      if (op_is_legal(alu_op)) begin
        rsp_result_d = alu_result;
        rsp_flags_d  = alu_flags;
        rsp_err_d    = 1'b0;
      end else begin
        rsp_result_d       = '0;
        rsp_flags_d        = '0;
        rsp_flags_d[FLG_Z] = 1'b1;
        rsp_err_d          = 1'b1;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

endmodule
`default_nettype wire

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Shares one combinational ALU instance between two requesters, for example the integer datapath and a debug or microcode sequencer.
- Arbitrates the two requesters round-robin using valid/ready handshakes.
- Drives the ALU, registers its result and flags in a single-entry response buffer, and returns them with requester ID and tag.
- Provides one-cycle latency and full throughput when the consumer does not stall.

Parameters:
- WIDTH, 32, operand and result width in bits (matches ALU).
- TAG_W, 4, width of the opaque tag carried from request to response.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req0_op  in  3  ALU control code.
- req0_tag  in  TAG_W  opaque tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_tag: same widths and meaning, requester 1.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the op (0 or 1).
- rsp_tag  out  TAG_W  tag of the issuing request.
- rsp_result  out  WIDTH  ALU result.
- rsp_flags  out  4  {Negative, Zero, Carry, OverFlow}.
- rsp_err  out  1  op code was illegal.

Behaviour:
- Op codes: 000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT, 111 XOR. Codes 100 and 110 are illegal.
- Slot free: can_issue = !rsp_valid | rsp_ready. A held response is either empty or leaving this cycle.
- Grant, combinational:
  - If can_issue is 0, nothing is granted.
  - If only one reqN_valid is high, that requester is granted.
  - If both are high, the requester selected by the priority pointer prio is granted.
- Ready: reqN_ready = grantN. Ready depends on valid. Requesters must hold a/b/op/tag stable while valid && !ready.
- Pointer update:
  - After a grant to N, prio <= ~N, so the other requester is favoured next.
  - With no grant, prio is unchanged.
  - Result: worst-case wait of one grant under continuous contention.
- ALU drive: the mux selects the granted requester's a/b/op into the ALU.
  - With no grant, the mux selects requester 0's inputs. The values are irrelevant.
- Capture on a grant edge:
  - rsp_valid <= 1.
  - rsp_id <= granted index; rsp_tag <= granted tag.
  - rsp_result <= ALU Result; rsp_flags <= ALU flags.
  - rsp_err <= 0.
- Illegal op: the op is accepted normally. Captured values are rsp_result = 0, rsp_flags = 0100 (Zero only), rsp_err = 1.
- Latency: request accepted at edge N; response visible after edge N with rsp_valid = 1. One cycle.
- Dequeue: rsp_valid && rsp_ready with no new grant -> rsp_valid <= 0. Payload is held; its value is don't-care.
- Simultaneous dequeue and grant, same edge: new payload loads and rsp_valid stays 1. Sustains one op per cycle.
- Backpressure: while rsp_valid && !rsp_ready, all rsp_* hold and both reqN_ready are 0.
- Reset (asserted any time, including mid-handshake):
  - rsp_valid = 0, rsp_id = 0, rsp_tag = 0, rsp_result = 0, rsp_flags = 0, rsp_err = 0.
  - prio = 0.
  - reqN_ready = 0 while rst is high.
  - An in-flight response is discarded.
- Width rules:
  - Flags are taken unmodified from the ALU.
  - SLT result is 0 or 1, zero-extended to WIDTH.

Decomposition:
- Shared package holds:
  - ALU op-code constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_XOR.
  - Flag bit indices: FLG_N = 3, FLG_Z = 2, FLG_C = 1, FLG_V = 0.
  - An op-legality function.
- One sub-module: rr_arb2, a 2-way round-robin arbiter holding prio. Inputs: req[1:0], en. Output: gnt[1:0].
- The existing ALU is instantiated unchanged.

Test Plan:
- req0 ADD a = 15, b = 10, tag = 3, rsp_ready = 1 -> next cycle rsp_valid = 1, rsp_id = 0, rsp_tag = 3, rsp_result = 25, rsp_flags = 0000, rsp_err = 0.
- req1 SUB 50 - 50, then req1 SUB 10 - 50 back-to-back -> both ready on consecutive cycles; result 0 with flags Z = 1, then 0xFFFFFFD8 with N = 1 and Z = 0.
- Both valid for 4 cycles, rsp_ready = 1, after reset -> grant order 0, 1, 0, 1; rsp_id sequence 0, 1, 0, 1.
- ADD 0x7FFFFFFF + 1 with rsp_ready = 0 for 3 cycles -> rsp_result = 0x80000000 with V = 1 and N = 1, held stable; reqN_ready = 0 throughout; released on rsp_ready = 1.
- op = 110 from req0 -> accepted; rsp_err = 1, rsp_result = 0, rsp_flags = 0100.
- Assert rst with rsp_valid = 1 and both requests pending -> outputs 0 immediately (async); after release the first contended grant goes to requester 0.
